arb_bus_ctrl: RTL and testbench

- Consumes the one-hot 4-bit Grant from the round-robin arbiter and turns it into a single-outstanding transfer on a shared slave port.
- Latches the granted master, muxes that master's address/write data/direction onto a valid/ready slave interface, and returns read data plus a one-cycle ack (or timeout error) to the owning master.
- Ignores Grant while a transfer is in flight; a one-cycle recovery state lets the master drop its request before the next grant is accepted.

---
 rtl/arb_pkg.sv | 23 ++
 rtl/arb_grant_mux.sv | 39 +++
 rtl/arb_bus_ctrl.sv | 157 +++++++++++++++
 tb/tb_arb_bus_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_pkg
// Brief    : Shared state encoding, master count and one-hot helper for the
//            arbiter/bus-controller family.
// Revision : 1.0
// ============================================================================
package arb_pkg;

    localparam int NUM_MASTERS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    function automatic logic onehot4(input logic [3:0] vec);
        return ($countones(vec) == 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_grant_mux.sv
`default_nettype none
// ============================================================================
// Module   : arb_grant_mux
// Brief    : Combinational one-hot selection of a master's address, write
//            data and direction by grant vector.
// Revision : 1.0
// ============================================================================
module arb_grant_mux
    import arb_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic [NUM_MASTERS-1:0]    grant,
    input  logic [NUM_MASTERS*AW-1:0] m_addr,
    input  logic [NUM_MASTERS*DW-1:0] m_wdata,
    input  logic [NUM_MASTERS-1:0]    m_we,
    output logic [AW-1:0]             sel_addr,
    output logic [DW-1:0]             sel_wdata,
    output logic                      sel_we
);

    // AND-OR mux: a non-one-hot grant yields an OR of masters, so callers
    // must qualify the grant before using the result.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant[i]) begin
                sel_addr  = sel_addr  | m_addr[i*AW +: AW];
                sel_wdata = sel_wdata | m_wdata[i*DW +: DW];
                sel_we    = sel_we    | m_we[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/arb_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : arb_bus_ctrl
// Brief    : Turns a one-hot arbiter grant into a single-outstanding
//            valid/ready slave transfer with ack/timeout back to the master.
// Revision : 1.0
// ============================================================================
module arb_bus_ctrl
    import arb_pkg::*;
#(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_MASTERS-1:0]    Grant,
    input  logic [NUM_MASTERS*AW-1:0] m_addr,
    input  logic [NUM_MASTERS*DW-1:0] m_wdata,
    input  logic [NUM_MASTERS-1:0]    m_we,
    output logic [NUM_MASTERS-1:0]    m_ack,
    output logic                      m_err,
    output logic [DW-1:0]             m_rdata,
    output logic                      s_valid,
    input  logic                      s_ready,
    output logic [AW-1:0]             s_addr,
    output logic [DW-1:0]             s_wdata,
    output logic                      s_we,
    input  logic [DW-1:0]             s_rdata,
    output logic                      busy
);

    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

    arb_state_e             r_state,   w_state_nxt;
    logic [NUM_MASTERS-1:0] r_owner,   w_owner_nxt;
    logic [7:0]             r_cnt,     w_cnt_nxt;
    logic                   r_s_valid, w_s_valid_nxt;
    logic [AW-1:0]          r_s_addr,  w_s_addr_nxt;
    logic [DW-1:0]          r_s_wdata, w_s_wdata_nxt;
    logic                   r_s_we,    w_s_we_nxt;
    logic [NUM_MASTERS-1:0] r_m_ack,   w_m_ack_nxt;
    logic                   r_m_err,   w_m_err_nxt;
    logic [DW-1:0]          r_m_rdata, w_m_rdata_nxt;
    logic                   r_busy;

    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;
    logic          w_sel_we;

    arb_grant_mux #(.AW(AW), .DW(DW)) u_grant_mux (
        .grant     (Grant),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_we      (m_we),
        .sel_addr  (w_sel_addr),
        .sel_wdata (w_sel_wdata),
        .sel_we    (w_sel_we)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_owner   <= '0;
            r_cnt     <= '0;
            r_s_valid <= 1'b0;
            r_s_addr  <= '0;
            r_s_wdata <= '0;
            r_s_we    <= 1'b0;
            r_m_ack   <= '0;
            r_m_err   <= 1'b0;
            r_m_rdata <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_cnt     <= w_cnt_nxt;
            r_s_valid <= w_s_valid_nxt;
            r_s_addr  <= w_s_addr_nxt;
            r_s_wdata <= w_s_wdata_nxt;
            r_s_we    <= w_s_we_nxt;
            r_m_ack   <= w_m_ack_nxt;
            r_m_err   <= w_m_err_nxt;
            r_m_rdata <= w_m_rdata_nxt;
            r_busy    <= (w_state_nxt != IDLE);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_cnt_nxt     = r_cnt;
        w_s_valid_nxt = r_s_valid;
        w_s_addr_nxt  = r_s_addr;
        w_s_wdata_nxt = r_s_wdata;
        w_s_we_nxt    = r_s_we;
        w_m_ack_nxt   = '0;
        w_m_err_nxt   = 1'b0;
        w_m_rdata_nxt = r_m_rdata;
        case (r_state)
            IDLE: begin
                if (onehot4(Grant)) begin
                    w_state_nxt   = XFER;
                    w_owner_nxt   = Grant;
                    w_s_addr_nxt  = w_sel_addr;
                    w_s_wdata_nxt = w_sel_wdata;
                    w_s_we_nxt    = w_sel_we;
                    w_s_valid_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                end
            end
            XFER: begin
                // Completion is tested first so a late s_ready beats the timeout.
                if (s_ready) begin
                    w_state_nxt   = DONE;
                    w_s_valid_nxt = 1'b0;
                    w_m_ack_nxt   = r_owner;
                    w_cnt_nxt     = '0;
                    if (!r_s_we) begin
                        w_m_rdata_nxt = s_rdata;
                    end
                end else if (r_cnt >= c_TO_LAST) begin
                    w_state_nxt   = DONE;
                    w_s_valid_nxt = 1'b0;
                    w_m_ack_nxt   = r_owner;
                    w_m_err_nxt   = 1'b1;
                    w_cnt_nxt     = '0;
                end else if (r_cnt != 8'hFF) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            DONE: begin
                w_state_nxt   = IDLE;
                w_owner_nxt   = '0;
                w_cnt_nxt     = '0;
                w_s_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt   = IDLE;
                w_owner_nxt   = '0;
                w_cnt_nxt     = '0;
                w_s_valid_nxt = 1'b0;
            end
        endcase
    end

    assign m_ack   = r_m_ack;
    assign m_err   = r_m_err;
    assign m_rdata = r_m_rdata;
    assign s_valid = r_s_valid;
    assign s_addr  = r_s_addr;
    assign s_wdata = r_s_wdata;
    assign s_we    = r_s_we;
    assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_arb_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb_bus_ctrl
// Brief    : Directed self-checking bench for arb_bus_ctrl.
// Revision : 1.0
// ============================================================================
module tb_arb_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  Grant;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_we;
    logic [3:0]  m_ack;
    logic        m_err;
    logic [7:0]  m_rdata;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_addr;
    logic [7:0]  s_wdata;
    logic        s_we;
    logic [7:0]  s_rdata;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int n_valid;

    always #5 clk = ~clk;

    arb_bus_ctrl #(.AW(8), .DW(8), .TIMEOUT(15)) dut (
        .clk     (clk),
        .rst     (rst),
        .Grant   (Grant),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_we    (m_we),
        .m_ack   (m_ack),
        .m_err   (m_err),
        .m_rdata (m_rdata),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_we    (s_we),
        .s_rdata (s_rdata),
        .busy    (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        Grant   = 4'b0001;
        m_addr  = {8'h40, 8'h30, 8'h3C, 8'h10};
        m_wdata = {8'h77, 8'h33, 8'h22, 8'h11};
        m_we    = 4'b1000;
        s_ready = 1'b0;
        s_rdata = 8'h00;

        // Reset held two cycles with a pending grant
        tick(); tick();
        chk("rst_s_valid", s_valid, 1'b0);
        chk("rst_busy",    busy,    1'b0);
        chk("rst_m_ack",   m_ack,   4'b0000);
        chk("rst_m_err",   m_err,   1'b0);
        chk("rst_m_rdata", m_rdata, 8'h00);
        chk("rst_s_addr",  s_addr,  8'h00);
        chk("rst_s_wdata", s_wdata, 8'h00);
        chk("rst_s_we",    s_we,    1'b0);

        rst = 1'b0;
        tick();
        chk("rel_s_valid", s_valid, 1'b1);
        chk("rel_s_addr",  s_addr,  8'h10);
        chk("rel_busy",    busy,    1'b1);
        Grant   = 4'b0000;
        s_ready = 1'b1;
        s_rdata = 8'h5A;
        tick();
        chk("rel_ack",    m_ack,   4'b0001);
        chk("rel_rdata",  m_rdata, 8'h5A);
        tick();
        chk("rel_idle",   busy,    1'b0);

        // Read from master 1 with slave always ready
        Grant   = 4'b0010;
        s_rdata = 8'hA5;
        tick();
        chk("rd_s_valid", s_valid, 1'b1);
        chk("rd_s_addr",  s_addr,  8'h3C);
        chk("rd_s_we",    s_we,    1'b0);
        chk("rd_busy_x",  busy,    1'b1);
        Grant = 4'b0000;
        tick();
        chk("rd_valid_off", s_valid, 1'b0);
        chk("rd_ack",     m_ack,   4'b0010);
        chk("rd_rdata",   m_rdata, 8'hA5);
        chk("rd_err",     m_err,   1'b0);
        chk("rd_busy_d",  busy,    1'b1);
        tick();
        chk("rd_ack_off", m_ack,   4'b0000);
        chk("rd_busy_i",  busy,    1'b0);

        // Write from master 3 with slow slave and grant moving mid-transfer
        s_ready = 1'b0;
        Grant   = 4'b1000;
        tick();
        chk("wr_s_valid", s_valid, 1'b1);
        chk("wr_s_wdata", s_wdata, 8'h77);
        chk("wr_s_addr",  s_addr,  8'h40);
        chk("wr_s_we",    s_we,    1'b1);
        Grant = 4'b0001;
        m_wdata[31:24] = 8'hEE;
        m_we[3] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wr_hold_valid", s_valid, 1'b1);
            chk("wr_hold_wdata", s_wdata, 8'h77);
            chk("wr_hold_we",    s_we,    1'b1);
        end
        tick();
        s_ready = 1'b1;
        s_rdata = 8'hC3;
        tick();
        chk("wr_ack",     m_ack,   4'b1000);
        chk("wr_err",     m_err,   1'b0);
        chk("wr_rdata",   m_rdata, 8'hA5);
        s_rdata = 8'h99;
        tick();
        chk("wr_idle_valid", s_valid, 1'b0);
        chk("wr_idle_ack",   m_ack,   4'b0000);
        tick();
        chk("m0_s_valid", s_valid, 1'b1);
        chk("m0_s_addr",  s_addr,  8'h10);
        Grant = 4'b0000;
        tick();
        chk("m0_ack",     m_ack,   4'b0001);
        chk("m0_rdata",   m_rdata, 8'h99);
        tick();

        // Timeout: slave never ready
        s_ready = 1'b0;
        Grant   = 4'b0100;
        tick();
        Grant   = 4'b0000;
        n_valid = 0;
        for (int i = 0; i < 40 && s_valid; i++) begin
            n_valid++;
            tick();
        end
        chk("to_valid_cycles", n_valid, 15);
        chk("to_ack",     m_ack,   4'b0100);
        chk("to_err",     m_err,   1'b1);
        chk("to_rdata",   m_rdata, 8'h99);
        tick();
        chk("to_busy",    busy,    1'b0);
        chk("to_err_off", m_err,   1'b0);

        // Ready arrives on the final count: success wins
        Grant = 4'b0100;
        tick();
        Grant = 4'b0000;
        repeat (13) tick();
        chk("late_valid14", s_valid, 1'b1);
        tick();
        chk("late_valid15", s_valid, 1'b1);
        s_ready = 1'b1;
        s_rdata = 8'h42;
        tick();
        chk("late_ack",   m_ack,   4'b0100);
        chk("late_err",   m_err,   1'b0);
        chk("late_rdata", m_rdata, 8'h42);
        s_ready = 1'b0;
        tick();

        // Illegal multi-bit grant
        Grant = 4'b0110;
        tick();
        chk("ill_valid",  s_valid, 1'b0);
        chk("ill_busy",   busy,    1'b0);
        tick();
        chk("ill_valid2", s_valid, 1'b0);
        chk("ill_busy2",  busy,    1'b0);

        // Reset in the middle of a transfer
        Grant = 4'b0001;
        tick();
        chk("rx_valid",   s_valid, 1'b1);
        Grant = 4'b0000;
        rst   = 1'b1;
        tick();
        chk("rx_valid_off", s_valid, 1'b0);
        chk("rx_ack",     m_ack,   4'b0000);
        chk("rx_err",     m_err,   1'b0);
        chk("rx_busy",    busy,    1'b0);
        rst = 1'b0;
        tick();
        chk("rx_ack2",    m_ack,   4'b0000);
        chk("rx_valid2",  s_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
